sbox7_inv_search: RTL

Sequential row-wise inverse of DES S-box 7. Each row of S7 is a permutation of 0..15, so a 2-bit row plus a 4-bit output nibble has exactly one 6-bit S-box input. The block finds that input by stepping a 4-bit column counter through one instance of the forward S7 table. It sits beside the DES round datapath and serves differential-analysis/debug logic and key-recovery test benches through a valid/ready request and response interface.

---
 rtl/des_sbox_pkg.sv | 29 ++
 rtl/sbox7_inv_search_if.sv | 19 +
 rtl/sbox7.sv | 25 ++
 rtl/sbox7_inv_search.sv | 96 +++++++++
 4 files changed

// File: rtl/des_sbox_pkg.sv
// Widths, search FSM states and Bin[6:1] pack/unpack helpers shared by the DES S-box inverse searchers.
// A 6-bit S-box input is {row[1], col[3:0], row[0]}.
package des_sbox_pkg;

    localparam int ROW_W  = 2;
    localparam int COL_W  = 4;
    localparam int SIN_W  = 6;
    localparam int SOUT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [SIN_W-1:0] pack_bin(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
        return {r[1], c, r[0]};
    endfunction

    function automatic logic [ROW_W-1:0] bin_row(input logic [SIN_W-1:0] b);
        return {b[5], b[0]};
    endfunction

    function automatic logic [COL_W-1:0] bin_col(input logic [SIN_W-1:0] b);
        return b[4:1];
    endfunction

endpackage

// File: rtl/sbox7_inv_search_if.sv
// Request/response bundle of the S7 inverse searcher: the request carries row and nibble,
// the response carries bin and err. Each direction has its own valid/ready pair.
interface sbox7_inv_search_if;
    import des_sbox_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ROW_W-1:0]  row;
    logic [SOUT_W-1:0] nibble;
    logic              out_valid;
    logic              out_ready;
    logic [SIN_W-1:0]  bin;
    logic              err;

    modport master (output in_valid, row, nibble, out_ready,
                    input  in_ready, out_valid, bin, err);
    modport slave  (input  in_valid, row, nibble, out_ready,
                    output in_ready, out_valid, bin, err);
endinterface

// File: rtl/sbox7.sv
// Forward DES S-box 7: 6-bit Bin[6:1] in, 4-bit nibble out. Purely combinational.
// Has no handshake; every input has an output in the same cycle.
module sbox7
    import des_sbox_pkg::*;
(
    input  logic [SIN_W-1:0]  sin,
    output logic [SOUT_W-1:0] sout
);

    logic [63:0] word;

    // Each row is packed with column 0 in the most significant nibble.
    always_comb begin
        word = '0;
        unique case (bin_row(sin))
            2'd0: word = 64'h4B2E_F08D_3C97_5A61;
            2'd1: word = 64'hD0B7_491A_E35C_2F86;
            2'd2: word = 64'h14BD_C37E_AF68_0592;
            2'd3: word = 64'h6BD8_14A7_950F_E23C;
        endcase
    end

    assign sout = word[{~bin_col(sin), 2'b00} +: SOUT_W];

endmodule

// File: rtl/sbox7_inv_search.sv
// Recovers the S7 input for a row/nibble pair by testing one column per cycle; result 2..17 cycles
// after accept (always 17 when EARLY_EXIT=0). Holds the result until out_ready, accepts only in IDLE.
module sbox7_inv_search
    import des_sbox_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    sbox7_inv_search_if.slave  bus
);

    state_t            state, state_nxt;
    logic [ROW_W-1:0]  row_q;
    logic [SOUT_W-1:0] nibble_q;
    logic [COL_W-1:0]  col;
    logic              found;
    logic [SIN_W-1:0]  bin_q;
    logic              err_q;

    logic [SIN_W-1:0]  sin;
    logic [SOUT_W-1:0] sout;
    logic              match;
    logic              last_col;

    assign sin      = pack_bin(row_q, col);
    assign match    = (state == SEARCH) && (sout == nibble_q);
    assign last_col = (col == {COL_W{1'b1}});

    sbox7 u_sbox7 (
        .sin  (sin),
        .sout (sout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Leaving SEARCH at the last column is unconditional, so col never wraps.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = SEARCH;
            SEARCH:  if ((EARLY_EXIT && match) || last_col) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    assign bus.bin = bin_q;
    assign bus.err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            nibble_q <= '0;
            col      <= '0;
            found    <= 1'b0;
            bin_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        row_q    <= bus.row;
                        nibble_q <= bus.nibble;
                        col      <= '0;
                        found    <= 1'b0;
                        bin_q    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (!last_col) col <= col + 1'b1;
                    // Only the first matching column is kept in constant-latency mode.
                    if (match && !found) begin
                        found <= 1'b1;
                        bin_q <= sin;
                    end else if (last_col && !found) begin
                        err_q <= 1'b1;
                        bin_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
